// File: rtl/eth_link_monitor.sv
// eth_link_monitor: per-channel debounced link state, link/activity LEDs,
// saturating drop counters and automatic transceiver relock requests.
module eth_link_monitor #(
  parameter int NUM_CH          = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int RELOCK_TIMEOUT  = 16777216,
  parameter int ACT_HOLD        = 4194304,
  parameter int BLINK_LOG2      = 23,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             rx_block_lock,
  input  logic [NUM_CH-1:0]             rx_high_ber,
  input  logic [NUM_CH-1:0]             rx_act_toggle,
  input  logic                          count_clr,
  output logic [NUM_CH-1:0]             link_up,
  output logic [2*NUM_CH-1:0]           led,
  output logic [NUM_CH*CNT_WIDTH-1:0]   drop_count,
  output logic [NUM_CH-1:0]             xcvr_rst_req
);
  localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = RELOCK_TIMEOUT > 1 ? $clog2(RELOCK_TIMEOUT) : 1;
  localparam int AW = $clog2(ACT_HOLD + 1);
  typedef enum logic [1:0] {DOWN, QUAL, UP} state_t;
  logic [BLINK_LOG2-1:0] blink_cnt, blink_cnt_n;
  logic                  blink_n;
  assign blink_cnt_n = blink_cnt + 1'b1;
  assign blink_n     = blink_cnt_n[BLINK_LOG2-1];
  always_ff @(posedge clk) begin
    if (!rst_n) blink_cnt <= '0;
    else        blink_cnt <= blink_cnt_n;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t               state, state_n;
    logic [1:0]           lock_ff, ber_ff;
    logic [2:0]           act_ff;
    logic [QW-1:0]        qual_cnt, qual_cnt_n;
    logic [TW-1:0]        timer, timer_n;
    logic [AW-1:0]        act_cnt, act_cnt_n;
    logic [CNT_WIDTH-1:0] drops, drops_n;
    logic                 lock_s, act_pulse, fire, link_led;
    logic                 up_r, led_link_r, led_act_r, req_r;
    assign lock_s    = lock_ff[1];
    assign act_pulse = act_ff[1] ^ act_ff[2];
    always_comb begin
      state_n    = state;
      qual_cnt_n = qual_cnt;
      timer_n    = '0;
      fire       = 1'b0;
      case (state)
        DOWN: begin
          if (lock_s) begin
            state_n    = QUAL;
            qual_cnt_n = QW'(1);
          end
        end
        QUAL: begin
          if (!lock_s) state_n = DOWN;
          else if (qual_cnt == QW'(DEBOUNCE_CYCLES)) state_n = UP;
          else qual_cnt_n = qual_cnt + 1'b1;
        end
        default: if (!lock_s) state_n = DOWN;
      endcase
      // reaching UP on the firing cycle suppresses the request
      if (state != UP && state_n != UP) begin
        fire    = RELOCK_TIMEOUT != 0 && timer == TW'(RELOCK_TIMEOUT - 1);
        timer_n = fire ? '0 : timer + 1'b1;
        if (fire) state_n = DOWN;
      end
      if (state_n == DOWN) qual_cnt_n = '0;
    end
    assign drops_n   = count_clr ? '0 :
                       (state == UP && !lock_s && !(&drops)) ? drops + 1'b1 : drops;
    assign act_cnt_n = (act_pulse && state == UP) ? AW'(ACT_HOLD) :
                       act_cnt != '0 ? act_cnt - 1'b1 : '0;
    assign link_led  = state_n == UP   ? (ber_ff[1] ? blink_n : 1'b1) :
                       state_n == QUAL ? blink_n : 1'b0;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        lock_ff    <= '0;
        ber_ff     <= '0;
        act_ff     <= '0;
        state      <= DOWN;
        qual_cnt   <= '0;
        timer      <= '0;
        act_cnt    <= '0;
        drops      <= '0;
        up_r       <= 1'b0;
        led_link_r <= 1'b0;
        led_act_r  <= 1'b0;
        req_r      <= 1'b0;
      end else begin
        lock_ff    <= {lock_ff[0], rx_block_lock[i]};
        ber_ff     <= {ber_ff[0], rx_high_ber[i]};
        act_ff     <= {act_ff[1:0], rx_act_toggle[i]};
        state      <= state_n;
        qual_cnt   <= qual_cnt_n;
        timer      <= timer_n;
        act_cnt    <= act_cnt_n;
        drops      <= drops_n;
        up_r       <= state_n == UP;
        led_link_r <= link_led;
        led_act_r  <= act_cnt_n != '0 && state_n == UP;
        req_r      <= fire;
      end
    end
    assign link_up[i]                              = up_r;
    assign led[2*i]                                = led_link_r;
    assign led[2*i+1]                              = led_act_r;
    assign drop_count[i*CNT_WIDTH +: CNT_WIDTH]    = drops;
    assign xcvr_rst_req[i]                         = req_r;
  end
endmodule

// File: tb/tb_eth_link_monitor.sv
// tb_eth_link_monitor: directed and random stimulus; a per-cycle reference
// model feeds a scoreboard queue that a negedge monitor drains.
module tb_eth_link_monitor;
  localparam int NC = 2, D = 8, T = 32, AH = 4, B = 3, CW = 4, HN = 8192;
  logic clk, rst_n, count_clr;
  logic [NC-1:0] lock, ber, tog, link_up, xcvr_rst_req;
  logic [2*NC-1:0] led;
  logic [NC*CW-1:0] drop_count;
  int vectors, miscompares;
  eth_link_monitor #(
    .NUM_CH(NC), .DEBOUNCE_CYCLES(D), .RELOCK_TIMEOUT(T),
    .ACT_HOLD(AH), .BLINK_LOG2(B), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_block_lock(lock), .rx_high_ber(ber),
    .rx_act_toggle(tog), .count_clr(count_clr), .link_up(link_up), .led(led),
    .drop_count(drop_count), .xcvr_rst_req(xcvr_rst_req)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // Reference model: synced inputs are the samples taken two edges earlier;
  // a lane is up once lock has stayed high for D+1 consecutive synced cycles.
  bit lock_h[NC][HN], ber_h[NC][HN], tog_h[NC][HN];
  int cyc, bc, run[NC], tmr[NC], drops[NC], act[NC];
  bit up[NC];
  logic [15:0] sb[$];
  always @(posedge clk) begin
    bit ls, bs, pl, nu, fire, blink;
    logic [1:0] e_link, e_req;
    logic [3:0] e_led;
    logic [7:0] e_drop;
    e_link = '0; e_req = '0; e_led = '0; e_drop = '0;
    bc = rst_n ? bc + 1 : 0;
    blink = ((bc >> (B - 1)) & 1) != 0;
    for (int c = 0; c < NC; c++) begin
      lock_h[c][cyc % HN] = rst_n & lock[c];
      ber_h[c][cyc % HN]  = rst_n & ber[c];
      tog_h[c][cyc % HN]  = rst_n & tog[c];
      if (!rst_n) begin
        run[c] = 0; tmr[c] = 0; drops[c] = 0; act[c] = 0; up[c] = 0;
      end else begin
        ls = cyc >= 2 && lock_h[c][(cyc - 2) % HN];
        bs = cyc >= 2 && ber_h[c][(cyc - 2) % HN];
        pl = cyc >= 3 && (tog_h[c][(cyc - 2) % HN] ^ tog_h[c][(cyc - 3) % HN]);
        nu = ls && (up[c] || run[c] == D);
        fire = 0;
        if (up[c] || nu) tmr[c] = 0;
        else if (tmr[c] == T - 1) begin fire = 1; tmr[c] = 0; end
        else tmr[c]++;
        if (count_clr) drops[c] = 0;
        else if (up[c] && !ls && drops[c] < (1 << CW) - 1) drops[c]++;
        act[c] = (pl && up[c]) ? AH : (act[c] > 0 ? act[c] - 1 : 0);
        run[c] = (ls && !nu && !fire) ? run[c] + 1 : 0;
        up[c] = nu;
        e_link[c] = nu;
        e_req[c] = fire;
        e_led[2*c] = nu ? (bs ? blink : 1'b1) : (run[c] > 0 ? blink : 1'b0);
        e_led[2*c+1] = act[c] > 0 && nu;
        e_drop[c*CW +: CW] = CW'(drops[c]);
      end
    end
    cyc++;
    sb.push_back({e_link, e_led, e_drop, e_req});
  end
  always @(negedge clk) begin
    logic [15:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("model", {link_up, led, drop_count, xcvr_rst_req}, e);
    end
  end
  task automatic wait_link(input int ch, input logic v, input int lim);
    int n = 0;
    while (link_up[ch] !== v && n < lim) begin @(posedge clk); #1; n++; end
    check("wait_link", link_up[ch], v);
  endtask
  initial begin
    int n, hi;
    bit saw0, saw1, stay;
    rst_n = 0; lock = 0; ber = 0; tog = 0; count_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {link_up, led, drop_count, xcvr_rst_req}, 0);
    rst_n = 1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      check("relock_req", xcvr_rst_req, (k % 32 == 31) ? 2'b11 : 2'b00);
    end
    lock[0] = 1;
    repeat (5) @(posedge clk);
    #1 lock[0] = 0;
    hi = 0;
    for (int k = 0; k < 15; k++) begin @(posedge clk); #1; hi += link_up[0]; end
    check("debounce_link", hi, 0);
    check("debounce_drops", drop_count[3:0], 0);
    n = 0;
    while (!xcvr_rst_req[0] && n < 40) begin @(posedge clk); #1; n++; end
    check("fire_seen", xcvr_rst_req[0], 1);
    lock[0] = 1;
    n = 0;
    while (!link_up[0] && n < 40) begin @(posedge clk); #1; n++; end
    check("link_latency", n, 11);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("link_led", {led[0], link_up[1]}, 2'b10);
    end
    tog[0] = ~tog[0];
    hi = 0;
    for (int k = 0; k < 12; k++) begin @(posedge clk); #1; hi += led[1]; end
    check("act_single", hi, 4);
    tog[0] = ~tog[0];
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      hi += led[1];
      if (k == 1) tog[0] = ~tog[0];
    end
    check("act_retrigger", hi, 6);
    ber[0] = 1;
    saw0 = 0; saw1 = 0; stay = 1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (led[0]) saw1 = 1; else saw0 = 1;
      stay &= link_up[0];
    end
    check("ber_blink", {saw0, saw1}, 2'b11);
    check("ber_link_stays", stay, 1);
    ber[0] = 0;
    for (int r = 0; r < 17; r++) begin
      lock[1] = 1; wait_link(1, 1, 80);
      lock[1] = 0; wait_link(1, 0, 10);
    end
    check("drop_saturate", drop_count[7:4], 4'hF);
    lock[1] = 1; wait_link(1, 1, 80);
    lock[1] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 count_clr = 1;
    @(posedge clk); #1 count_clr = 0;
    check("clear_wins", drop_count[7:4], 0);
    check("clear_link_dropped", link_up[1], 0);
    lock[0] = 0; wait_link(0, 0, 10);
    tog[0] = ~tog[0];
    hi = 0;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; hi += led[1]; end
    check("act_while_down", hi, 0);
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, lock[c] ? 39 : 7) == 0) lock[c] = ~lock[c];
        if ($urandom_range(0, 24) == 0) ber[c] = ~ber[c];
        if ($urandom_range(0, 2) == 0) tog[c] = ~tog[c];
      end
      count_clr = $urandom_range(0, 59) == 0;
    end
    count_clr = 0;
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
